execute_cycle: RTL and testbench

Execute stage of the pipelined core, between the ID/EX boundary and the memory stage. Selects forwarded operands, performs ALU and branch/jump resolution, and registers results into the EX/MEM pipeline register that feeds the memory stage. Includes an iterative shift-add multiplier that stalls the front end while it runs.

---
 rtl/core_pkg.sv | 26 ++
 rtl/seq_multiplier.sv | 94 +++++++++
 rtl/execute_cycle.sv | 175 +++++++++++++++++
 tb/tb_execute_cycle.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: ALU operation codes, forwarding selects and the
// multiplier state encoding used by the execute stage.
package core_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_MUL = 4'b1001;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, product held
// in the accumulator for the single DONE cycle.
module seq_multiplier
  import core_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic              idle_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  mul_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // Next state; a flush abandons the product from any state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d  = BUSY;
            mcand_d  = op_a_i;
            mplier_d = op_b_i;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end else begin
            acc_d = acc_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign idle_o    = (state_q == IDLE);
  assign busy_o    = (state_q == BUSY);
  assign done_o    = (state_q == DONE);
  assign product_o = acc_q;

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register, with a multi-cycle multiplier that stalls fetch.
module execute_cycle
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_E,
  input  logic              flush_E,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic              ALUSrcE,
  input  logic [3:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] Imm_Ext_E,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  input  logic [DATA_W-1:0] ResultW,
  output logic              stall_E,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [REG_AW-1:0] RD_M,
  output logic [DATA_W-1:0] PCPlus4M,
  output logic [DATA_W-1:0] ALU_ResultM,
  output logic [DATA_W-1:0] WriteDataM
);

  logic [DATA_W-1:0] src_a_s, src_b_s, write_data_s, alu_res_s, product_s;
  logic [4:0]        shamt_s;
  logic              zero_s, is_mul_s, mul_start_s;
  logic              mul_idle_s, mul_busy_s, mul_done_s, bubble_s;

  logic              reg_write_q, reg_write_d;
  logic              mem_write_q, mem_write_d;
  logic              result_src_q, result_src_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] pc_plus4_q, pc_plus4_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Forward mux A; the unused code 11 falls back to the register file
  always_comb begin
    src_a_s = RD1_E;
    case (ForwardA_E)
      FWD_RF:  src_a_s = RD1_E;
      FWD_WB:  src_a_s = ResultW;
      FWD_MEM: src_a_s = ALU_ResultM;
      default: src_a_s = RD1_E;
    endcase
  end

  // Forward mux B, which is also the store data
  always_comb begin
    write_data_s = RD2_E;
    case (ForwardB_E)
      FWD_RF:  write_data_s = RD2_E;
      FWD_WB:  write_data_s = ResultW;
      FWD_MEM: write_data_s = ALU_ResultM;
      default: write_data_s = RD2_E;
    endcase
  end

  assign src_b_s  = ALUSrcE ? Imm_Ext_E : write_data_s;
  assign shamt_s  = src_b_s[4:0];
  assign is_mul_s = (ALUControlE == ALU_MUL);

  // ALU; the MUL result is only meaningful while the multiplier sits in DONE
  always_comb begin
    alu_res_s = '0;
    case (ALUControlE)
      ALU_ADD: alu_res_s = src_a_s + src_b_s;
      ALU_SUB: alu_res_s = src_a_s - src_b_s;
      ALU_AND: alu_res_s = src_a_s & src_b_s;
      ALU_OR:  alu_res_s = src_a_s | src_b_s;
      ALU_XOR: alu_res_s = src_a_s ^ src_b_s;
      ALU_SLT: alu_res_s = ($signed(src_a_s) < $signed(src_b_s)) ? DATA_W'(1) : DATA_W'(0);
      ALU_SLL: alu_res_s = src_a_s << shamt_s;
      ALU_SRL: alu_res_s = src_a_s >> shamt_s;
      ALU_SRA: alu_res_s = $signed(src_a_s) >>> shamt_s;
      ALU_MUL: alu_res_s = product_s;
      default: alu_res_s = '0;
    endcase
  end

  assign zero_s      = (alu_res_s == '0);
  assign mul_start_s = valid_E & ~flush_E & is_mul_s;

  seq_multiplier #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start_s),
    .flush_i   (flush_E),
    .op_a_i    (src_a_s),
    .op_b_i    (src_b_s),
    .idle_o    (mul_idle_s),
    .busy_o    (mul_busy_s),
    .done_o    (mul_done_s),
    .product_o (product_s)
  );

  // DONE releases the stall, so the front end steps past the MUL on the
  // edge that leaves DONE and the instruction is never re-issued.
  assign stall_E   = rst & ~flush_E & ((mul_idle_s & valid_E & is_mul_s) | mul_busy_s);
  assign PCSrcE    = valid_E & ~flush_E & ~mul_busy_s & ((BranchE & zero_s) | JumpE);
  assign PCTargetE = PCE + Imm_Ext_E;
  assign bubble_s  = stall_E | flush_E | ~valid_E;

  // EX/MEM next value: bubble or the current instruction
  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    result_src_d = 1'b0;
    rd_d         = '0;
    pc_plus4_d   = '0;
    alu_d        = '0;
    wdata_d      = '0;
    if (bubble_s) begin
      reg_write_d = 1'b0;
      mem_write_d = 1'b0;
    end else begin
      reg_write_d  = RegWriteE;
      mem_write_d  = MemWriteE;
      result_src_d = ResultSrcE;
      rd_d         = RD_E;
      pc_plus4_d   = PCPlus4E;
      alu_d        = (mul_done_s && is_mul_s) ? product_s : alu_res_s;
      wdata_d      = write_data_s;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
      alu_q        <= '0;
      wdata_q      <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      alu_q        <= alu_d;
      wdata_q      <= wdata_d;
    end
  end

  assign RegWriteM   = reg_write_q;
  assign MemWriteM   = mem_write_q;
  assign ResultSrcM  = result_src_q;
  assign RD_M        = rd_q;
  assign PCPlus4M    = pc_plus4_q;
  assign ALU_ResultM = alu_q;
  assign WriteDataM  = wdata_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed testbench for execute_cycle with a scoreboard of expected EX/MEM
// contents, one entry per clock edge.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_E, flush_E;
  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        stall_E, PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] wd;
  } mexp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        alusrc;
    logic [31:0] res;
  } alu_vec_t;

  mexp_t    sb_q[$];
  alu_vec_t vecs[$];
  int       n_tests = 0;
  int       n_fail  = 0;

  always #5 clk = ~clk;

  execute_cycle dut (
    .clk(clk), .rst(rst), .valid_E(valid_E), .flush_E(flush_E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RD_E(RD_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .stall_E(stall_E), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_m(input string tag, input mexp_t expv);
    mexp_t got;
    got = '{RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, ALU_ResultM, WriteDataM};
    n_tests++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, expv);
    end
  endtask

  task automatic push(input logic rw, input logic [4:0] rd, input logic [31:0] pc4,
                      input logic [31:0] alu, input logic [31:0] wd);
    sb_q.push_back('{rw, 1'b0, 1'b0, rd, pc4, alu, wd});
  endtask

  task automatic push_bubble();
    sb_q.push_back('0);
  endtask

  // Advance one edge and compare the EX/MEM register against the oldest expectation
  task automatic tick_chk(input string tag);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
    end else begin
      chk_m(tag, sb_q.pop_front());
    end
  endtask

  task automatic set_idle();
    valid_E = 1'b0; flush_E = 1'b0;
    RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 1'b0;
    BranchE = 1'b0; JumpE = 1'b0; ALUSrcE = 1'b0; ALUControlE = 4'b0000;
    RD1_E = 32'h0; RD2_E = 32'h0; Imm_Ext_E = 32'h0; PCE = 32'h0; PCPlus4E = 32'h0;
    ResultW = 32'h0; RD_E = 5'd0; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] pc4);
    set_idle();
    valid_E = 1'b1; RegWriteE = 1'b1; ALUControlE = op;
    RD1_E = a; RD2_E = b; RD_E = rd; PCPlus4E = pc4;
  endtask

  // Issue a MUL, expect 33 stall cycles of bubbles, then the product
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    p = a * b;
    drive_op(4'b1001, a, b, 5'd7, 32'h0000_0200);
    #1;
    for (int i = 0; i < 33; i++) begin
      chk({tag, "_stall"}, {31'b0, stall_E}, 32'd1);
      push_bubble();
      tick_chk({tag, "_bubble"});
      if (i == 5) begin
        RD1_E = 32'hDEAD_BEEF;
        ResultW = 32'h5555_5555;
      end
      #1;
    end
    chk({tag, "_done_stall"}, {31'b0, stall_E}, 32'd0);
    push(1'b1, 5'd7, 32'h0000_0200, p, b);
    tick_chk({tag, "_product"});
    set_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs.push_back('{4'b0000, 32'h0000_0005, 32'h0000_0007, 32'h0, 1'b0, 32'h0000_000C});
    vecs.push_back('{4'b0000, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 1'b0, 32'h0000_0001});
    vecs.push_back('{4'b0001, 32'h0000_0003, 32'h0000_0005, 32'h0, 1'b0, 32'hFFFF_FFFE});
    vecs.push_back('{4'b0010, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0, 1'b0, 32'h0000_00F0});
    vecs.push_back('{4'b0011, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0, 1'b0, 32'h0000_FFF0});
    vecs.push_back('{4'b0100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0, 1'b0, 32'h0000_FF00});
    vecs.push_back('{4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 32'h0000_0001});
    vecs.push_back('{4'b0101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0000_0000});
    vecs.push_back('{4'b0110, 32'h0000_0001, 32'h0000_0123, 32'd31, 1'b1, 32'h8000_0000});
    vecs.push_back('{4'b0111, 32'h8000_0000, 32'h0000_0004, 32'h0, 1'b0, 32'h0800_0000});
    vecs.push_back('{4'b1000, 32'h8000_0000, 32'h0000_0004, 32'h0, 1'b0, 32'hF800_0000});
    vecs.push_back('{4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0, 1'b0, 32'h0000_0000});

    // Reset state
    rst = 1'b0;
    set_idle();
    #1;
    chk("reset_stall", {31'b0, stall_E}, 32'd0);
    chk_m("reset_m", '0);
    push_bubble();
    tick_chk("reset_hold");
    rst = 1'b1;

    // ALU operation table
    foreach (vecs[k]) begin
      drive_op(vecs[k].op, vecs[k].a, vecs[k].b, 5'd3, 32'h0000_0104);
      Imm_Ext_E = vecs[k].imm;
      ALUSrcE = vecs[k].alusrc;
      #1;
      chk("alu_stall", {31'b0, stall_E}, 32'd0);
      push(1'b1, 5'd3, 32'h0000_0104, vecs[k].res, vecs[k].b);
      tick_chk($sformatf("alu_vec%0d", k));
    end

    // Forwarding: ALU_ResultM = 0x10 first, then SUB with A from MEM, B from WB
    drive_op(4'b0000, 32'h0000_0010, 32'h0, 5'd9, 32'h0000_0108);
    #1;
    push(1'b1, 5'd9, 32'h0000_0108, 32'h0000_0010, 32'h0);
    tick_chk("fwd_setup");
    drive_op(4'b0001, 32'h0000_AAAA, 32'h0000_BBBB, 5'd10, 32'h0000_010C);
    ForwardA_E = 2'b10; ForwardB_E = 2'b01; ResultW = 32'h0000_0003;
    #1;
    push(1'b1, 5'd10, 32'h0000_010C, 32'h0000_000D, 32'h0000_0003);
    tick_chk("fwd_sub");

    // BEQ taken / not taken
    drive_op(4'b0001, 32'd9, 32'd9, 5'd0, 32'h0000_0044);
    RegWriteE = 1'b0; BranchE = 1'b1; PCE = 32'h0000_0040; Imm_Ext_E = 32'h0000_0008;
    #1;
    chk("beq_pcsrc", {31'b0, PCSrcE}, 32'd1);
    chk("beq_target", PCTargetE, 32'h0000_0048);
    push(1'b0, 5'd0, 32'h0000_0044, 32'h0, 32'd9);
    tick_chk("beq_m");
    RD2_E = 32'd8;
    #1;
    chk("bne_pcsrc", {31'b0, PCSrcE}, 32'd0);
    push(1'b0, 5'd0, 32'h0000_0044, 32'd1, 32'd8);
    tick_chk("bne_m");

    // Jump, target wrap, then flushed jump and an invalid slot
    drive_op(4'b0000, 32'd1, 32'd1, 5'd1, 32'h0000_0050);
    JumpE = 1'b1; PCE = 32'hFFFF_FFF0; Imm_Ext_E = 32'h0000_0020;
    #1;
    chk("jal_pcsrc", {31'b0, PCSrcE}, 32'd1);
    chk("target_wrap", PCTargetE, 32'h0000_0010);
    push(1'b1, 5'd1, 32'h0000_0050, 32'd2, 32'd1);
    tick_chk("jal_m");
    flush_E = 1'b1;
    #1;
    chk("flush_pcsrc", {31'b0, PCSrcE}, 32'd0);
    push_bubble();
    tick_chk("flush_bubble");
    flush_E = 1'b0; valid_E = 1'b0;
    #1;
    push_bubble();
    tick_chk("invalid_bubble");

    // Multiplies
    run_mul("mul1", 32'h0000_1234, 32'h0000_0100);
    run_mul("mul2", 32'hFFFF_FFFF, 32'h0000_0002);

    // MUL issued together with flush: no stall, no issue
    drive_op(4'b1001, 32'd3, 32'd4, 5'd7, 32'h0);
    flush_E = 1'b1;
    #1;
    chk("flush_issue_stall", {31'b0, stall_E}, 32'd0);
    push_bubble();
    tick_chk("flush_issue_m");
    drive_op(4'b0000, 32'd2, 32'd2, 5'd4, 32'h0000_0300);
    #1;
    chk("flush_issue_idle", {31'b0, stall_E}, 32'd0);
    push(1'b1, 5'd4, 32'h0000_0300, 32'd4, 32'd2);
    tick_chk("flush_issue_add");

    // Flush ten cycles into a MUL
    drive_op(4'b1001, 32'd7, 32'd9, 5'd7, 32'h0);
    #1;
    for (int i = 0; i < 10; i++) begin
      push_bubble();
      tick_chk("mflush_bubble");
      #1;
    end
    chk("mflush_busy", {31'b0, stall_E}, 32'd1);
    flush_E = 1'b1;
    #1;
    chk("mflush_stall", {31'b0, stall_E}, 32'd0);
    push_bubble();
    tick_chk("mflush_m");
    drive_op(4'b0000, 32'd1, 32'd2, 5'd4, 32'h0000_0400);
    #1;
    chk("mflush_idle", {31'b0, stall_E}, 32'd0);
    push(1'b1, 5'd4, 32'h0000_0400, 32'd3, 32'd2);
    tick_chk("mflush_add");

    // Reset in the middle of a MUL
    drive_op(4'b1001, 32'd5, 32'd6, 5'd7, 32'h0);
    #1;
    for (int i = 0; i < 5; i++) begin
      push_bubble();
      tick_chk("rmul_bubble");
      #1;
    end
    rst = 1'b0;
    #1;
    chk("rmul_stall", {31'b0, stall_E}, 32'd0);
    chk_m("rmul_m", '0);
    set_idle();
    push_bubble();
    tick_chk("rmul_hold");
    rst = 1'b1;
    drive_op(4'b0000, 32'd20, 32'd22, 5'd5, 32'h0000_0500);
    #1;
    chk("rmul_idle", {31'b0, stall_E}, 32'd0);
    push(1'b1, 5'd5, 32'h0000_0500, 32'd42, 32'd22);
    tick_chk("rmul_add");

    // Reset while an ALU result sits in EX/MEM
    rst = 1'b0;
    #1;
    chk_m("ralu_m", '0);
    chk("ralu_stall", {31'b0, stall_E}, 32'd0);
    push_bubble();
    tick_chk("ralu_hold");
    rst = 1'b1;
    drive_op(4'b0000, 32'd100, 32'd23, 5'd6, 32'h0000_0600);
    #1;
    push(1'b1, 5'd6, 32'h0000_0600, 32'd123, 32'd23);
    tick_chk("ralu_add");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
